execute_pipeline_ctrl: RTL and testbench
========================================

# execute_pipeline_ctrl

Pipeline sequencing controller for the Execute stage of the 16-bit pipelined core. It watches the instruction in ID and the instruction in EX, together with the ALU flags. From these it generates stall, bubble, flush and PC-redirect controls for:
- load-use hazards,
- taken branches/jumps,
- the multi-cycle MUL operation that occupies the Execute ALU.

It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- MUL_LAT, 4, cycles a MUL occupies EX (legal 2..16)
- OP_MUL, 5'b00010, multiply opcode
- OP_LOAD, 5'b10000, load opcode
- OP_JMP, 5'b11000, unconditional jump
- OP_BEQ, 5'b11001, branch if ZF
- OP_BGT, 5'b11010, branch if GF
- OP_BLT, 5'b11011, branch if LF

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID/IF-ID register holds a real instruction
- id_src1, id_src2  in  5 each  ID source register indices; index 0 = unused/$R0
- ex_valid  in  1  ID/EX register holds a real instruction
- ex_opcode  in  5  opcode in EX (Execute control_in)
- ex_dest  in  5  destination index in EX
- ZF, GF, LF  in  1 each  Execute flags, valid in same cycle as ex_opcode
- ex_target  in  16  branch/jump target from Execute
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP (ex_valid=0) into ID/EX at next edge
- flush  out  1  clear IF/ID register at next edge
- ex_hold  out  1  hold ID/EX and EX/MEM input of the current EX instruction
- pc_sel  out  1  1 = PC loads pc_target at next edge
- pc_target  out  16  redirect address
- mul_busy  out  1  state is MUL_WAIT
- stall_count  out  16  saturating count of cycles with stall=1
- flush_count  out  16  saturating count of taken branches/jumps

## Operation
- States: RUN, MUL_WAIT. 4-bit down-counter mul_cnt.
- Control outputs are Mealy: combinational from state, mul_cnt and inputs. Counters and state are registered.
- RUN, evaluated in priority order:
  1. **Taken redirect.** Condition: ex_valid and one of ex_opcode==OP_JMP, OP_BEQ&ZF, OP_BGT&GF, OP_BLT&LF. Response: pc_sel=1, pc_target=ex_target, flush=1, bubble=1, stall=0. A not-taken branch produces no outputs.
  2. **MUL start.** Condition: ex_valid and ex_opcode==OP_MUL. Response: ex_hold=1, stall=1. Next state MUL_WAIT, mul_cnt←MUL_LAT-2.
  3. **Load-use.** Condition: ex_valid, ex_opcode==OP_LOAD, ex_dest!=0, id_valid, and (id_src1==ex_dest or id_src2==ex_dest). Response: stall=1, bubble=1 for exactly one cycle.
  4. Otherwise all control outputs are 0.
- MUL_WAIT:
  - mul_cnt!=0: ex_hold=1, stall=1, mul_cnt decrements.
  - mul_cnt==0: ex_hold=0, stall=0. The MUL leaves EX at this edge; next state RUN.
  - Load-use and redirect are not evaluated. EX holds a MUL, so neither can occur.
- pc_target = ex_target when pc_sel=1, else 16'h0000.
- Counters increment by 1 per qualifying cycle and hold at 16'hFFFF. A load-use cycle and each MUL-held cycle count as stalls. Redirect cycles count in flush_count only.

## Timing
- Reset (sampled at edge while reset=1):
  - state←RUN, mul_cnt←0, stall_count←0, flush_count←0.
  - While reset=1, all combinational outputs are forced to 0, including pc_target.
- Reset mid-MUL abandons the multiply. The first cycle after reset is RUN.
- Redirect latency: 0 cycles to outputs; PC holds the target one edge later. Penalty is 2 killed instructions (the IF/ID and ID-to-EX slots).
- MUL occupies EX for exactly MUL_LAT cycles:
  - MUL_LAT=2: one RUN hold cycle plus one MUL_WAIT release cycle.
  - stall is high for MUL_LAT-1 cycles.
- Load-use costs exactly 1 bubble. The following cycle, EX holds the bubble, so stall does not repeat.
- Back-to-back MULs: the release cycle returns to RUN. The next MUL is detected the cycle it reaches EX.
- ex_valid=0 suppresses every rule, including a stale opcode.

## Test plan
- **Reset:** assert reset 2 cycles mid-MUL (MUL_LAT=4). Required: all outputs 0, mul_busy=0 after release, counters 0.
- **Load-use:** EX={LOAD, dest=3}, ID={src1=3}. Required: stall=1, bubble=1 for one cycle; stall_count=1. Repeat with dest=0. Required: no stall.
- **MUL:** MUL_LAT=4, MUL enters EX at cycle t. Required: ex_hold/stall high t..t+2, low at t+3; mul_busy high t+1..t+3; stall_count=3.
- **Branch:**
  - OP_BEQ with ZF=1, ex_target=16'h0040. Required: pc_sel=1, pc_target=16'h0040, flush=1, bubble=1; flush_count=1.
  - Same with ZF=0. Required: all outputs 0.
  - OP_BGT/GF and OP_BLT/LF with the matching flag set. Required: redirect.
- **Saturation:** hold load-use stall for 65540 cycles. Required: stall_count stops at 16'hFFFF.
- **Invalid:** ex_valid=0 with ex_opcode=OP_JMP. Required: pc_sel=0, flush=0.

Source files
------------

// File: rtl/execute_pipeline_ctrl.sv
// Execute-stage sequencing for the 16-bit core: load-use bubbles, branch/jump
// redirects, multi-cycle MUL occupancy, and saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | normal issue; redirect, MUL start and load-use are evaluated
// MUL_WAIT | MUL held in EX; r_mul_cnt counts remaining hold cycles

module execute_pipeline_ctrl #(
    parameter int          MUL_LAT = 4,
    parameter logic [4:0]  OP_MUL  = 5'b00010,
    parameter logic [4:0]  OP_LOAD = 5'b10000,
    parameter logic [4:0]  OP_JMP  = 5'b11000,
    parameter logic [4:0]  OP_BEQ  = 5'b11001,
    parameter logic [4:0]  OP_BGT  = 5'b11010,
    parameter logic [4:0]  OP_BLT  = 5'b11011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [4:0]  ex_dest,
    input  logic        ZF,
    input  logic        GF,
    input  logic        LF,
    input  logic [15:0] ex_target,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic        ex_hold,
    output logic        pc_sel,
    output logic [15:0] pc_target,
    output logic        mul_busy,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // The RUN start cycle is the first hold cycle, so the wait phase needs MUL_LAT-2 more.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_mul_cnt;
    logic [3:0]  w_next_mul_cnt;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic w_taken;
    logic w_mul_start;
    logic w_load_use;
    logic w_src_match;

    logic w_stall;
    logic w_bubble;
    logic w_flush;
    logic w_ex_hold;
    logic w_pc_sel;

    always_comb begin
        w_taken = 1'b0;
        if (ex_valid) begin
            if (ex_opcode == OP_JMP)
                w_taken = 1'b1;
            else if (ex_opcode == OP_BEQ && ZF)
                w_taken = 1'b1;
            else if (ex_opcode == OP_BGT && GF)
                w_taken = 1'b1;
            else if (ex_opcode == OP_BLT && LF)
                w_taken = 1'b1;
        end
    end

    assign w_mul_start = ex_valid && (ex_opcode == OP_MUL);
    assign w_src_match = (id_src1 == ex_dest) || (id_src2 == ex_dest);
    // $R0 is never written, so a load targeting it cannot create a hazard.
    assign w_load_use  = ex_valid && (ex_opcode == OP_LOAD) && (ex_dest != 5'd0) &&
                         id_valid && w_src_match;

    always_comb begin
        w_next_state   = r_state;
        w_next_mul_cnt = r_mul_cnt;
        w_stall        = 1'b0;
        w_bubble       = 1'b0;
        w_flush        = 1'b0;
        w_ex_hold      = 1'b0;
        w_pc_sel       = 1'b0;

        case (r_state)
            RUN: begin
                if (w_taken) begin
                    w_pc_sel = 1'b1;
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_mul_start) begin
                    w_ex_hold      = 1'b1;
                    w_stall        = 1'b1;
                    w_next_state   = MUL_WAIT;
                    w_next_mul_cnt = MUL_CNT_INIT;
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end

            MUL_WAIT: begin
                if (r_mul_cnt != 4'd0) begin
                    w_ex_hold      = 1'b1;
                    w_stall        = 1'b1;
                    w_next_mul_cnt = r_mul_cnt - 4'd1;
                end else begin
                    w_next_state = RUN;
                end
            end

            default: begin
                w_next_state   = RUN;
                w_next_mul_cnt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_mul_cnt     <= 4'd0;
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            r_state   <= w_next_state;
            r_mul_cnt <= w_next_mul_cnt;
            if (w_stall && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (w_pc_sel && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    // Control outputs are forced low while reset is held, even mid-MUL.
    assign stall       = w_stall   & ~reset;
    assign bubble      = w_bubble  & ~reset;
    assign flush       = w_flush   & ~reset;
    assign ex_hold     = w_ex_hold & ~reset;
    assign pc_sel      = w_pc_sel  & ~reset;
    assign pc_target   = (w_pc_sel && !reset) ? ex_target : 16'h0000;
    assign mul_busy    = (r_state == MUL_WAIT) && !reset;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_execute_pipeline_ctrl.sv
// Self-checking bench for execute_pipeline_ctrl: table-driven single-cycle
// vectors, MUL/reset sequences and counter saturation through a scoreboard.

module tb_execute_pipeline_ctrl;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_LOAD = 5'b10000;
    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_BEQ  = 5'b11001;
    localparam logic [4:0] OP_BGT  = 5'b11010;
    localparam logic [4:0] OP_BLT  = 5'b11011;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_src1, id_src2;
    logic        ex_valid;
    logic [4:0]  ex_opcode, ex_dest;
    logic        ZF, GF, LF;
    logic [15:0] ex_target;
    logic        stall, bubble, flush, ex_hold, pc_sel, mul_busy;
    logic [15:0] pc_target, stall_count, flush_count;

    always #5 clk = ~clk;

    execute_pipeline_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
        .ZF(ZF), .GF(GF), .LF(LF), .ex_target(ex_target),
        .stall(stall), .bubble(bubble), .flush(flush), .ex_hold(ex_hold),
        .pc_sel(pc_sel), .pc_target(pc_target), .mul_busy(mul_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        id_v;
        logic [4:0]  s1, s2;
        logic        ex_v;
        logic [4:0]  op, dst;
        logic        zf, gf, lf;
        logic [15:0] tgt;
        logic        e_stall, e_bubble, e_flush, e_hold, e_pcsel, e_busy;
        logic [15:0] e_tgt;
    } vec_t;

    typedef struct {
        string       name;
        logic        stall, bubble, flush, hold, pcsel, busy;
        logic [15:0] tgt, scnt, fcnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_scnt, m_fcnt;

    function automatic vec_t mk(string name, logic rst, logic id_v, logic [4:0] s1, logic [4:0] s2,
                                logic ex_v, logic [4:0] op, logic [4:0] dst,
                                logic zf, logic gf, logic lf, logic [15:0] tgt,
                                logic e_stall, logic e_bubble, logic e_flush, logic e_hold,
                                logic e_pcsel, logic [15:0] e_tgt, logic e_busy);
        vec_t v;
        v.name = name; v.rst = rst; v.id_v = id_v; v.s1 = s1; v.s2 = s2;
        v.ex_v = ex_v; v.op = op; v.dst = dst; v.zf = zf; v.gf = gf; v.lf = lf; v.tgt = tgt;
        v.e_stall = e_stall; v.e_bubble = e_bubble; v.e_flush = e_flush; v.e_hold = e_hold;
        v.e_pcsel = e_pcsel; v.e_tgt = e_tgt; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; id_valid = v.id_v; id_src1 = v.s1; id_src2 = v.s2;
        ex_valid = v.ex_v; ex_opcode = v.op; ex_dest = v.dst;
        ZF = v.zf; GF = v.gf; LF = v.lf; ex_target = v.tgt;
    endtask

    // Drive one cycle at posedge+1, push expectation, compare at negedge.
    task automatic apply(input vec_t v);
        exp_t e, g;
        drive(v);
        e.name = v.name; e.stall = v.e_stall; e.bubble = v.e_bubble; e.flush = v.e_flush;
        e.hold = v.e_hold; e.pcsel = v.e_pcsel; e.busy = v.e_busy; e.tgt = v.e_tgt;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        sb.push_back(e);
        if (v.rst) begin
            m_scnt = 16'd0;
            m_fcnt = 16'd0;
        end else begin
            if (v.e_stall && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (v.e_pcsel && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
        end
        @(negedge clk);
        g = sb.pop_front();
        chk({g.name, ".stall"},       {15'd0, stall},    {15'd0, g.stall});
        chk({g.name, ".bubble"},      {15'd0, bubble},   {15'd0, g.bubble});
        chk({g.name, ".flush"},       {15'd0, flush},    {15'd0, g.flush});
        chk({g.name, ".ex_hold"},     {15'd0, ex_hold},  {15'd0, g.hold});
        chk({g.name, ".pc_sel"},      {15'd0, pc_sel},   {15'd0, g.pcsel});
        chk({g.name, ".mul_busy"},    {15'd0, mul_busy}, {15'd0, g.busy});
        chk({g.name, ".pc_target"},   pc_target,   g.tgt);
        chk({g.name, ".stall_count"}, stall_count, g.scnt);
        chk({g.name, ".flush_count"}, flush_count, g.fcnt);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t idle, mul_hold, mul_wait, mul_rel, rst_jmp, lu;

    initial begin
        idle     = mk("idle",     0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0, 0);
        mul_hold = mk("mul_t",    0, 1, 4, 4, 1, OP_MUL, 4, 0, 0, 0, 16'h0,    1, 0, 0, 1, 0, 16'h0, 0);
        mul_wait = mk("mul_wait", 0, 1, 4, 4, 1, OP_MUL, 4, 0, 0, 0, 16'h0,    1, 0, 0, 1, 0, 16'h0, 1);
        mul_rel  = mk("mul_rel",  0, 1, 4, 4, 1, OP_MUL, 4, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0, 1);
        rst_jmp  = mk("rst_jmp",  1, 1, 4, 4, 1, OP_JMP, 4, 1, 1, 1, 16'hBEEF, 0, 0, 0, 0, 0, 16'h0, 0);
        lu       = mk("sat_lu",   0, 1, 3, 0, 1, OP_LOAD,3, 0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 16'h0, 0);

        tbl.push_back(mk("lu_dest3",    0, 1, 3, 7, 1, OP_LOAD, 3, 0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("lu_dest0",    0, 1, 0, 0, 1, OP_LOAD, 0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("lu_src2",     0, 1, 1, 5, 1, OP_LOAD, 5, 0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("lu_id_inv",   0, 0, 3, 3, 1, OP_LOAD, 3, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("lu_nomatch",  0, 1, 2, 4, 1, OP_LOAD, 3, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("lu_stale",    0, 1, 3, 3, 0, OP_LOAD, 3, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("beq_taken",   0, 0, 0, 0, 1, OP_BEQ,  0, 1, 0, 0, 16'h0040, 0, 1, 1, 0, 1, 16'h0040, 0));
        tbl.push_back(mk("beq_not",     0, 0, 0, 0, 1, OP_BEQ,  0, 0, 1, 1, 16'h0040, 0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("bgt_taken",   0, 1, 2, 2, 1, OP_BGT,  2, 0, 1, 0, 16'h1234, 0, 1, 1, 0, 1, 16'h1234, 0));
        tbl.push_back(mk("blt_taken",   0, 0, 0, 0, 1, OP_BLT,  0, 0, 0, 1, 16'hABCD, 0, 1, 1, 0, 1, 16'hABCD, 0));
        tbl.push_back(mk("bgt_wrongf",  0, 0, 0, 0, 1, OP_BGT,  0, 1, 0, 1, 16'h2222, 0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("jmp_invalid", 0, 0, 0, 0, 0, OP_JMP,  0, 0, 0, 0, 16'h3333, 0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("jmp_taken",   0, 1, 6, 6, 1, OP_JMP,  6, 0, 0, 0, 16'hFFFE, 0, 1, 1, 0, 1, 16'hFFFE, 0));
        tbl.push_back(mk("mul_invalid", 0, 0, 0, 0, 0, OP_MUL,  0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk("alu_plain",   0, 1, 1, 2, 1, OP_ADD,  1, 1, 1, 1, 16'h5555, 0, 0, 0, 0, 0, 16'h0,    0));

        // Initial reset to define counters before any comparison
        drive(rst_jmp);
        m_scnt = 16'd0;
        m_fcnt = 16'd0;
        @(posedge clk);
        #1;
        apply(rst_jmp);
        apply(idle);

        foreach (tbl[i]) apply(tbl[i]);
        apply(idle);

        // MUL with MUL_LAT=4, then a back-to-back MUL after the release cycle
        apply(mul_hold);
        apply(mul_wait);
        apply(mul_wait);
        apply(mul_rel);
        apply(mul_hold);
        apply(mul_wait);
        apply(mul_wait);
        apply(mul_rel);
        apply(idle);

        // Reset for two cycles in the middle of a MUL
        apply(mul_hold);
        apply(mul_wait);
        apply(rst_jmp);
        apply(rst_jmp);
        apply(idle);
        chk("rst_mid_mul.stall_count_zero", stall_count, 16'h0000);

        // Counter saturation under a continuous load-use
        drive(lu);
        for (int i = 0; i < 65540; i++) begin
            if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            @(posedge clk);
            #1;
        end
        apply(lu);
        apply(lu);
        chk("sat.stall_count_max", stall_count, 16'hFFFF);
        apply(idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
